// File: rtl/delay_probe_pkg.sv
// Shared definitions for the delay-path probe sequencer.
//   probe_state_t   : sequencer states
//   RECOVER_CYCLES  : settle time after each capture
//   DEFAULT_*       : default widths used by the top level and the result interface
package delay_probe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RECOVER = 3'd4,
        ST_REPORT  = 3'd5
    } probe_state_t;

    localparam int RECOVER_CYCLES    = 8;
    localparam int DEFAULT_NUM_PATHS = 4;
    localparam int DEFAULT_TRIALS_W  = 8;
    localparam int DEFAULT_WAIT_W    = 4;

endpackage

// File: rtl/delay_path_probe_ctrl_if.sv
// Result stream of the delay-path probe sequencer (valid/ready).
//   res_valid : result available          (master -> slave)
//   res_ready : consumer accepts result    (slave -> master)
//   res_path  : path index of the result   (master -> slave)
//   res_hits  : arrivals counted for path  (master -> slave)
interface delay_path_probe_ctrl_if
    import delay_probe_pkg::*;
#(
    parameter int NUM_PATHS = DEFAULT_NUM_PATHS,
    parameter int TRIALS_W  = DEFAULT_TRIALS_W
) ();
    logic                         res_valid;
    logic                         res_ready;
    logic [$clog2(NUM_PATHS)-1:0] res_path;
    logic [TRIALS_W-1:0]          res_hits;

    modport master (output res_valid, output res_path, output res_hits, input res_ready);
    modport slave  (input res_valid, input res_path, input res_hits, output res_ready);
endinterface

// File: rtl/probe_capture.sv
// Per-bit sampling stage for the asynchronous path results.
// Macro PROBE_SYNC_EN:
//   defined   : two-flop synchronizer per bit (metastability-safe, extra latency
//               moves the effective capture point earlier than in raw mode)
//   undefined : a single capture flop per bit (raw sensor mode)
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   din      : raw path results
//   dout     : sampled path results
module probe_capture #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
`ifdef PROBE_SYNC_EN
            logic metaReg;
            logic syncReg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    metaReg <= 1'b0;
                    syncReg <= 1'b0;
                end else begin
                    metaReg <= din[gi];
                    syncReg <= metaReg;
                end
            end
            assign dout[gi] = syncReg;
`else
            logic capReg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    capReg <= 1'b0;
                end else begin
                    capReg <= din[gi];
                end
            end
            assign dout[gi] = capReg;
`endif
        end
    endgenerate
endmodule

// File: rtl/delay_path_probe_ctrl.sv
// Delay-path probe sequencer: launches a transition into each path in turn,
// samples the path output W cycles later, counts in-time arrivals over the
// programmed number of trials and reports one hit count per path.
// Optional macro PROBE_SYNC_EN selects a 2-flop synchronizer in probe_capture.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a campaign (IDLE only, ignored when trials == 0)
//   trials        : launches per path, latched on accepted start
//   wait_cycles   : launch-to-capture wait, latched on start, 0 behaves as 1
//   path_launch   : registered launch level per path
//   path_result   : asynchronous path outputs
//   busy          : campaign in progress
//   resIf         : result stream (valid/ready, path index, hit count)
module delay_path_probe_ctrl
    import delay_probe_pkg::*;
#(
    parameter int NUM_PATHS = DEFAULT_NUM_PATHS,
    parameter int TRIALS_W  = DEFAULT_TRIALS_W,
    parameter int WAIT_W    = DEFAULT_WAIT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [TRIALS_W-1:0]   trials,
    input  logic [WAIT_W-1:0]     wait_cycles,
    output logic [NUM_PATHS-1:0]  path_launch,
    input  logic [NUM_PATHS-1:0]  path_result,
    output logic                  busy,
    delay_path_probe_ctrl_if.master resIf
);
    localparam int PIDX_W = $clog2(NUM_PATHS);
    // One down-counter serves both WAIT and RECOVER, so it must hold either length.
    localparam int CNT_W  = (WAIT_W > 3) ? WAIT_W : 3;

    probe_state_t         stateReg, stateNext;
    logic [PIDX_W-1:0]    pathReg;
    logic [TRIALS_W-1:0]  trialReg, hitsReg, trialsCfgReg;
    logic [WAIT_W-1:0]    waitCfgReg;
    logic [CNT_W-1:0]     cntReg;
    logic [NUM_PATHS-1:0] launchReg, toggleVec, capturedVec;
    logic                 startOk, cntDone, lastPath, arrived, resFire;
    logic                 resValid;
    logic [PIDX_W-1:0]    resPath;
    logic [TRIALS_W-1:0]  resHits;

    probe_capture #(.WIDTH(NUM_PATHS)) u_capture (
        .clk  (clk),
        .rst  (rst),
        .din  (path_result),
        .dout (capturedVec)
    );

    assign startOk  = start && (trials != '0);
    assign cntDone  = (cntReg == '0);
    assign lastPath = (pathReg == PIDX_W'(NUM_PATHS - 1));
    assign arrived  = (capturedVec[pathReg] == launchReg[pathReg]);
    assign resFire  = resValid && resIf.res_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= ST_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = stateReg;
        unique case (stateReg)
            ST_IDLE:    if (startOk) stateNext = ST_LAUNCH;
            ST_LAUNCH:  stateNext = ST_WAIT;
            ST_WAIT:    if (cntDone) stateNext = ST_CAPTURE;
            ST_CAPTURE: stateNext = ST_RECOVER;
            ST_RECOVER: if (cntDone) stateNext = (trialReg < trialsCfgReg) ? ST_LAUNCH : ST_REPORT;
            ST_REPORT:  if (resFire) stateNext = lastPath ? ST_IDLE : ST_LAUNCH;
            default:    stateNext = ST_IDLE;
        endcase
    end

    // Outputs; result fields read as zero outside REPORT
    always_comb begin
        busy     = (stateReg != ST_IDLE);
        resValid = (stateReg == ST_REPORT);
        resPath  = resValid ? pathReg : '0;
        resHits  = resValid ? hitsReg : '0;
    end

    assign resIf.res_valid = resValid;
    assign resIf.res_path  = resPath;
    assign resIf.res_hits  = resHits;
    assign path_launch     = launchReg;

    // Counters and latched configuration
    always_ff @(posedge clk) begin
        if (rst) begin
            pathReg      <= '0;
            trialReg     <= '0;
            hitsReg      <= '0;
            trialsCfgReg <= '0;
            waitCfgReg   <= '0;
            cntReg       <= '0;
        end else begin
            case (stateReg)
                ST_IDLE: begin
                    if (startOk) begin
                        trialsCfgReg <= trials;
                        waitCfgReg   <= (wait_cycles == '0) ? WAIT_W'(1) : wait_cycles;
                        pathReg      <= '0;
                        trialReg     <= '0;
                        hitsReg      <= '0;
                    end
                end
                // Load W-1 so WAIT lasts exactly W cycles.
                ST_LAUNCH: cntReg <= CNT_W'(waitCfgReg) - 1'b1;
                ST_WAIT: if (!cntDone) cntReg <= cntReg - 1'b1;
                ST_CAPTURE: begin
                    if (arrived && (hitsReg != '1)) begin
                        hitsReg <= hitsReg + 1'b1;
                    end
                    trialReg <= trialReg + 1'b1;
                    cntReg   <= CNT_W'(RECOVER_CYCLES - 1);
                end
                ST_RECOVER: if (!cntDone) cntReg <= cntReg - 1'b1;
                ST_REPORT: begin
                    if (resFire && !lastPath) begin
                        pathReg  <= pathReg + 1'b1;
                        trialReg <= '0;
                        hitsReg  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Only the selected path toggles, on the edge that leaves LAUNCH; the rest
    // keep their level, and levels carry over between campaigns.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PATHS; gi++) begin : g_toggle
            assign toggleVec[gi] = (stateReg == ST_LAUNCH) && (pathReg == PIDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            launchReg <= '0;
        end else begin
            launchReg <= launchReg ^ toggleVec;
        end
    end
endmodule

// File: tb/tb_delay_path_probe_ctrl.sv
module tb_delay_path_probe_ctrl;
    localparam int NUM_PATHS = 4;
    localparam int TRIALS_W  = 8;
    localparam int WAIT_W    = 4;
    localparam int PIDX_W    = $clog2(NUM_PATHS);
    localparam int LIMIT     = 3000;
    localparam int M_LOOP = 0, M_ST0 = 1, M_ST1 = 2, M_DLY = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [TRIALS_W-1:0]  trials;
    logic [WAIT_W-1:0]    wait_cycles;
    logic [NUM_PATHS-1:0] path_launch;
    logic [NUM_PATHS-1:0] path_result;
    logic                 busy;

    int total = 0;
    int bad   = 0;
    int srcMode  = M_LOOP;
    int srcDelay = 1;
    logic [NUM_PATHS-1:0] modelLvl = '0;
    logic [NUM_PATHS-1:0] dly [0:15];

    delay_path_probe_ctrl_if #(.NUM_PATHS(NUM_PATHS), .TRIALS_W(TRIALS_W)) resIf ();

    delay_path_probe_ctrl #(
        .NUM_PATHS(NUM_PATHS), .TRIALS_W(TRIALS_W), .WAIT_W(WAIT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .trials      (trials),
        .wait_cycles (wait_cycles),
        .path_launch (path_launch),
        .path_result (path_result),
        .busy        (busy),
        .resIf       (resIf)
    );

    always #5 clk = ~clk;

    // Model of the delay-path bank: stage i is path_launch delayed i+1 cycles.
    always @(posedge clk) begin
        dly[0] <= path_launch;
        for (int i = 1; i < 16; i++) dly[i] <= dly[i-1];
    end

    always_comb begin
        path_result = path_launch;
        case (srcMode)
            M_ST0:   path_result = '0;
            M_ST1:   path_result = '1;
            M_DLY:   path_result = dly[srcDelay-1];
            default: path_result = path_launch;
        endcase
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Does a launch of level lvl, sampled W cycles later, arrive in time?
    function automatic bit arrives(input logic lvl, input int md, input int dl, input int w);
        case (md)
            M_ST0:   return (lvl == 1'b0);
            M_ST1:   return (lvl == 1'b1);
            M_DLY:   return (dl < w);
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_campaign(input string tag, input int tr, input int wc, input int md,
                                input int dl, input int stallPath, input bit pulse);
        int w, expHits, cyc, n;
        logic [31:0] hp, hh;
        logic [NUM_PATHS-1:0] hl;
        w = (wc == 0) ? 1 : wc;
        n = tr * (w + 10);
        srcMode = md;
        srcDelay = dl;
        @(negedge clk);
        start = 1'b1; trials = TRIALS_W'(tr); wait_cycles = WAIT_W'(wc);
        @(negedge clk);
        start = 1'b0;
        check($sformatf("%s_busy_after_start", tag), busy, 1);
        for (int p = 0; p < NUM_PATHS; p++) begin
            expHits = 0;
            for (int k = 0; k < tr; k++) begin
                modelLvl[p] = ~modelLvl[p];
                if (arrives(modelLvl[p], md, dl, w)) expHits++;
            end
            cyc = 0;
            while (resIf.res_valid !== 1'b1 && cyc < LIMIT) begin
                @(negedge clk);
                cyc++;
                if (pulse && p == 0 && cyc == 2) begin
                    start = 1'b1; trials = 8'd9; wait_cycles = 4'd1;
                end else if (pulse && p == 0 && cyc == 3) begin
                    start = 1'b0; trials = TRIALS_W'(tr); wait_cycles = WAIT_W'(wc);
                end
            end
            check($sformatf("%s_p%0d_valid", tag, p), resIf.res_valid, 1);
            check($sformatf("%s_p%0d_latency", tag, p), cyc, n);
            check($sformatf("%s_p%0d_path", tag, p), resIf.res_path, p);
            check($sformatf("%s_p%0d_hits", tag, p), resIf.res_hits, expHits);
            check($sformatf("%s_p%0d_launch", tag, p), path_launch, modelLvl);
            $display("%s path=%0d hits=%0d expected=%0d latency=%0d", tag, resIf.res_path,
                     resIf.res_hits, expHits, cyc);
            if (p == stallPath) begin
                hp = resIf.res_path; hh = resIf.res_hits; hl = path_launch;
                for (int s = 0; s < 10; s++) begin
                    @(negedge clk);
                    check($sformatf("%s_stall%0d_valid", tag, s), resIf.res_valid, 1);
                    check($sformatf("%s_stall%0d_path", tag, s), resIf.res_path, hp);
                    check($sformatf("%s_stall%0d_hits", tag, s), resIf.res_hits, hh);
                    check($sformatf("%s_stall%0d_launch", tag, s), path_launch, hl);
                end
            end
            resIf.res_ready = 1'b1;
            @(negedge clk);
            resIf.res_ready = 1'b0;
            check($sformatf("%s_p%0d_valid_drop", tag, p), resIf.res_valid, 0);
            check($sformatf("%s_p%0d_busy_after", tag, p), busy, (p != NUM_PATHS - 1));
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int seen, cyc;
        rst = 1'b1; start = 1'b0; trials = '0; wait_cycles = '0;
        resIf.res_ready = 1'b0;
        repeat (20) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_valid", resIf.res_valid, 0);
        check("reset_launch", path_launch, 0);
        check("reset_path", resIf.res_path, 0);
        check("reset_hits", resIf.res_hits, 0);
        rst = 1'b0;
        @(negedge clk);

        run_campaign("loopback", 4, 3, M_LOOP, 0, -1, 1'b0);
        run_campaign("stuck0", 4, 2, M_ST0, 0, -1, 1'b0);
        run_campaign("stuck1_w0", 4, 0, M_ST1, 0, -1, 1'b0);
        run_campaign("backpressure", 2, 1, M_LOOP, 0, 1, 1'b0);

        // start with trials == 0 is ignored
        @(negedge clk);
        start = 1'b1; trials = '0; wait_cycles = 4'd3;
        @(negedge clk);
        start = 1'b0;
        check("zero_trials_busy", busy, 0);
        @(negedge clk);
        check("zero_trials_busy2", busy, 0);
        check("zero_trials_valid", resIf.res_valid, 0);

        run_campaign("start_while_busy", 3, 2, M_ST0, 0, -1, 1'b1);
        run_campaign("delay5_w4", 2, 4, M_DLY, 5, -1, 1'b0);
        run_campaign("delay5_w6", 2, 6, M_DLY, 5, -1, 1'b0);

        // Reset in the middle of WAIT for path 2
        srcMode = M_LOOP;
        resIf.res_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; trials = 8'd2; wait_cycles = 4'd5;
        @(negedge clk);
        start = 1'b0;
        seen = 0; cyc = 0;
        while (seen < 2 && cyc < LIMIT) begin
            if (resIf.res_valid === 1'b1) seen++;
            @(negedge clk);
            cyc++;
        end
        check("midwait_results_seen", seen, 2);
        @(negedge clk);
        modelLvl[2] = ~modelLvl[2];
        check("midwait_busy", busy, 1);
        check("midwait_launch", path_launch, modelLvl);
        rst = 1'b1;
        resIf.res_ready = 1'b0;
        @(negedge clk);
        modelLvl = '0;
        check("midwait_rst_busy", busy, 0);
        check("midwait_rst_valid", resIf.res_valid, 0);
        check("midwait_rst_launch", path_launch, 0);
        check("midwait_rst_path", resIf.res_path, 0);
        check("midwait_rst_hits", resIf.res_hits, 0);
        $display("reset mid-WAIT busy=%0d launch=%0h", busy, path_launch);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run_campaign("after_reset", 3, 2, M_LOOP, 0, -1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            int md, dl, tr, wc;
            md = int'($urandom_range(0, 3));
            dl = int'($urandom_range(1, 8));
            tr = int'($urandom_range(1, 4));
            wc = int'($urandom_range(0, 15));
            run_campaign($sformatf("random%0d_m%0d_d%0d_t%0d_w%0d", r, md, dl, tr, wc),
                         tr, wc, md, dl, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
